// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: IR/CON inputs and the full control word of the single-bus CPU datapath.
// master = control unit, slave = datapath. Macro MEM_WAIT_EN adds the mem_ready input.
interface cpu_control_unit_if #(
   parameter int unsigned OPW = 5
);
   logic [31:0]    IR;
   logic           CON;
`ifdef MEM_WAIT_EN
   logic           mem_ready;
`endif
   logic           run;
   logic           PCout, incPC, PCin, MARin, MDRin, MDRout, read, write;
   logic           Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic           Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout;
   logic           IRin, CONN_in, InPortout, OutPortIn;
   logic [OPW-1:0] alu_op;

   modport master (
      input  IR,
      input  CON,
`ifdef MEM_WAIT_EN
      input  mem_ready,
`endif
      output run,
      output PCout, incPC, PCin, MARin, MDRin, MDRout, read, write,
      output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      output Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout,
      output IRin, CONN_in, InPortout, OutPortIn,
      output alu_op
   );

   modport slave (
      output IR,
      output CON,
`ifdef MEM_WAIT_EN
      output mem_ready,
`endif
      input  run,
      input  PCout, incPC, PCin, MARin, MDRin, MDRout, read, write,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      input  Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout,
      input  IRin, CONN_in, InPortout, OutPortIn,
      input  alu_op
   );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired Moore sequencer (T0..T7 + HALT) for the single-bus CPU.
// Controls are decoded from the current step, IR[31:27] and CON; clr forces them to 0.
// Optional macro MEM_WAIT_EN: steps issuing read/write hold until mem_ready=1.
module cpu_control_unit #(
   parameter int unsigned    OPW    = 5,
   parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
   input logic                clk,
   input logic                clr,
   cpu_control_unit_if.master bus
);

   typedef enum logic [3:0] {
      StT0   = 4'd0,
      StT1   = 4'd1,
      StT2   = 4'd2,
      StT3   = 4'd3,
      StT4   = 4'd4,
      StT5   = 4'd5,
      StT6   = 4'd6,
      StT7   = 4'd7,
      StHalt = 4'd8
   } state_t;

   typedef struct packed {
      logic pc_out, inc_pc, pc_in, mar_in, mdr_in, mdr_out, read, write;
      logic gra, grb, grc, r_in, r_out, ba_out, c_out;
      logic y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, hi_out, lo_out;
      logic ir_in, con_in, inport_out, outport_in;
   } ctl_t;

   localparam logic [OPW-1:0] OpLd   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OpLdi  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OpSt   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OpRol  = OPW'(5'b01011);
   localparam logic [OPW-1:0] OpAddi = OPW'(5'b01100);
   localparam logic [OPW-1:0] OpOri  = OPW'(5'b01110);
   localparam logic [OPW-1:0] OpMul  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OpDiv  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OpNeg  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OpNot  = OPW'(5'b10010);
   localparam logic [OPW-1:0] OpBr   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OpJr   = OPW'(5'b10100);
   localparam logic [OPW-1:0] OpJal  = OPW'(5'b10101);
   localparam logic [OPW-1:0] OpIn   = OPW'(5'b10110);
   localparam logic [OPW-1:0] OpOut  = OPW'(5'b10111);
   localparam logic [OPW-1:0] OpMfhi = OPW'(5'b11000);
   localparam logic [OPW-1:0] OpMflo = OPW'(5'b11001);
   localparam logic [OPW-1:0] OpHalt = OPW'(5'b11011);

   state_t         state_q, state_d;
   ctl_t           ctl;
   logic           last;
   logic           go_halt;
   logic           stall;
   logic           active;
   logic [OPW-1:0] op;
   logic [OPW-1:0] alu_sel;
   logic [31-OPW:0] unused_ir;

   assign op        = bus.IR[31 -: OPW];
   assign unused_ir = bus.IR[31-OPW:0];

   // Decode the control word of the current step and whether it ends the instruction.
   always_comb begin
      ctl     = '0;
      last    = 1'b0;
      go_halt = 1'b0;
      unique case (state_q)
         StT0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; end
         StT1: begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
         StT2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
         StHalt: ;
         default: begin
            // Any step not listed for an opcode falls back to fetch.
            last = 1'b1;
            if (op == OpLd || op == OpLdi || op == OpSt) begin
               case (state_q)
                  StT3: begin
                     ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                     last = 1'b0;
                  end
                  StT4: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; last = 1'b0; end
                  StT5: begin
                     ctl.zlo_out = 1'b1;
                     if (op == OpLdi) begin
                        ctl.gra = 1'b1; ctl.r_in = 1'b1;
                     end else begin
                        ctl.mar_in = 1'b1; last = 1'b0;
                     end
                  end
                  StT6: begin
                     if (op == OpLd) begin
                        ctl.read = 1'b1; ctl.mdr_in = 1'b1; last = 1'b0;
                     end else if (op == OpSt) begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; last = 1'b0;
                     end
                  end
                  StT7: begin
                     if (op == OpLd) begin
                        ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                     end else if (op == OpSt) begin
                        ctl.write = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end else if ((op >= OpAdd && op <= OpRol) || (op >= OpAddi && op <= OpOri)) begin
               case (state_q)
                  StT3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; last = 1'b0; end
                  StT4: begin
                     ctl.z_in = 1'b1; last = 1'b0;
                     if (op <= OpRol) begin
                        ctl.grc = 1'b1; ctl.r_out = 1'b1;
                     end else begin
                        ctl.c_out = 1'b1;
                     end
                  end
                  StT5: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                  default: ;
               endcase
            end else if (op == OpMul || op == OpDiv) begin
               case (state_q)
                  StT3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; last = 1'b0; end
                  StT4: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; last = 1'b0; end
                  StT5: begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; last = 1'b0; end
                  StT6: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
                  default: ;
               endcase
            end else if (op == OpNeg || op == OpNot) begin
               case (state_q)
                  StT3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; last = 1'b0; end
                  StT4: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                  default: ;
               endcase
            end else if (op == OpBr) begin
               case (state_q)
                  StT3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; last = 1'b0; end
                  StT4: begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; last = 1'b0; end
                  StT5: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; last = 1'b0; end
                  StT6: begin ctl.zlo_out = 1'b1; ctl.pc_in = bus.CON; end
                  default: ;
               endcase
            end else if (op == OpJal) begin
               case (state_q)
                  StT3: begin ctl.pc_out = 1'b1; ctl.grb = 1'b1; ctl.r_in = 1'b1; last = 1'b0; end
                  StT4: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                  default: ;
               endcase
            end else if (state_q == StT3) begin
               // Single-step opcodes; nop and unused codes assert nothing.
               if (op == OpJr) begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1;
               end else if (op == OpIn) begin
                  ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end else if (op == OpOut) begin
                  ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1;
               end else if (op == OpMfhi) begin
                  ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end else if (op == OpMflo) begin
                  ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
               end else if (op == OpHalt) begin
                  go_halt = 1'b1;
               end
            end
         end
      endcase
   end

`ifdef MEM_WAIT_EN
   assign stall = (ctl.read | ctl.write) & ~bus.mem_ready;
`else
   assign stall = 1'b0;
`endif

   // Step sequencing: hold in HALT or on a memory stall, otherwise advance or wrap to T0.
   always_comb begin
      state_d = state_q;
      if (state_q == StHalt || stall) begin
         state_d = state_q;
      end else if (go_halt) begin
         state_d = StHalt;
      end else if (last) begin
         state_d = StT0;
      end else begin
         state_d = state_t'(state_q + 4'd1);
      end
   end

   // State register; clr overrides everything, including a stall.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StT0;
      end else begin
         state_q <= state_d;
      end
   end

   assign active  = ~clr & (state_q != StHalt);
   assign alu_sel = (op == OpLd || op == OpLdi || op == OpSt || op == OpBr) ? ADD_OP : op;

   assign bus.run       = clr | (state_q != StHalt);
   assign bus.alu_op    = active ? alu_sel : '0;
   assign bus.PCout     = active & ctl.pc_out;
   assign bus.incPC     = active & ctl.inc_pc;
   assign bus.PCin      = active & ctl.pc_in;
   assign bus.MARin     = active & ctl.mar_in;
   assign bus.MDRin     = active & ctl.mdr_in;
   assign bus.MDRout    = active & ctl.mdr_out;
   assign bus.read      = active & ctl.read;
   assign bus.write     = active & ctl.write;
   assign bus.Gra       = active & ctl.gra;
   assign bus.Grb       = active & ctl.grb;
   assign bus.Grc       = active & ctl.grc;
   assign bus.Rin       = active & ctl.r_in;
   assign bus.Rout      = active & ctl.r_out;
   assign bus.BAout     = active & ctl.ba_out;
   assign bus.Cout      = active & ctl.c_out;
   assign bus.Yin       = active & ctl.y_in;
   assign bus.Zin       = active & ctl.z_in;
   assign bus.ZLowOut   = active & ctl.zlo_out;
   assign bus.ZHighOut  = active & ctl.zhi_out;
   assign bus.HIin      = active & ctl.hi_in;
   assign bus.LOin      = active & ctl.lo_in;
   assign bus.HIout     = active & ctl.hi_out;
   assign bus.LOout     = active & ctl.lo_out;
   assign bus.IRin      = active & ctl.ir_in;
   assign bus.CONN_in   = active & ctl.con_in;
   assign bus.InPortout = active & ctl.inport_out;
   assign bus.OutPortIn = active & ctl.outport_in;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: table-driven instruction vectors with an expected-control-word queue.
module tb_cpu_control_unit;

   localparam logic [26:0] PCOUT   = 27'h1 << 26;
   localparam logic [26:0] INCPC   = 27'h1 << 25;
   localparam logic [26:0] PCIN    = 27'h1 << 24;
   localparam logic [26:0] MARIN   = 27'h1 << 23;
   localparam logic [26:0] MDRIN   = 27'h1 << 22;
   localparam logic [26:0] MDROUT  = 27'h1 << 21;
   localparam logic [26:0] READ    = 27'h1 << 20;
   localparam logic [26:0] WRITE   = 27'h1 << 19;
   localparam logic [26:0] GRA     = 27'h1 << 18;
   localparam logic [26:0] GRB     = 27'h1 << 17;
   localparam logic [26:0] GRC     = 27'h1 << 16;
   localparam logic [26:0] RIN     = 27'h1 << 15;
   localparam logic [26:0] ROUT    = 27'h1 << 14;
   localparam logic [26:0] BAOUT   = 27'h1 << 13;
   localparam logic [26:0] COUT    = 27'h1 << 12;
   localparam logic [26:0] YIN     = 27'h1 << 11;
   localparam logic [26:0] ZIN     = 27'h1 << 10;
   localparam logic [26:0] ZLOW    = 27'h1 << 9;
   localparam logic [26:0] ZHIGH   = 27'h1 << 8;
   localparam logic [26:0] HIIN    = 27'h1 << 7;
   localparam logic [26:0] LOIN    = 27'h1 << 6;
   localparam logic [26:0] HIOUT   = 27'h1 << 5;
   localparam logic [26:0] LOOUT   = 27'h1 << 4;
   localparam logic [26:0] IRIN    = 27'h1 << 3;
   localparam logic [26:0] CONNIN  = 27'h1 << 2;
   localparam logic [26:0] INPORT  = 27'h1 << 1;
   localparam logic [26:0] OUTPORT = 27'h1 << 0;
   localparam logic [26:0] NONE    = 27'h0;

   localparam logic [26:0] F0 = PCOUT | MARIN | INCPC;
   localparam logic [26:0] F1 = READ | MDRIN;
   localparam logic [26:0] F2 = MDROUT | IRIN;

   typedef struct {
      logic [26:0] ctl;
      logic        run;
      logic        chk_alu;
      logic [4:0]  alu;
      string       name;
   } exp_t;

   typedef struct {
      string            name;
      logic [31:0]      ir;
      logic             con;
      int               n;
      logic [4:0][26:0] ex;
      logic [4:0]       alu;
   } vec_t;

   logic        clk;
   logic        clr;
   logic [26:0] act_ctl;
   exp_t        q[$];
   exp_t        cur;
   vec_t        vecs[22];
   int          n_tests;
   int          n_fail;

   cpu_control_unit_if #(.OPW(5)) bus ();

   cpu_control_unit dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act_ctl = {bus.PCout, bus.incPC, bus.PCin, bus.MARin, bus.MDRin, bus.MDRout,
                     bus.read, bus.write, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                     bus.BAout, bus.Cout, bus.Yin, bus.Zin, bus.ZLowOut, bus.ZHighOut,
                     bus.HIin, bus.LOin, bus.HIout, bus.LOout, bus.IRin, bus.CONN_in,
                     bus.InPortout, bus.OutPortIn};

   // One expected entry is consumed per cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         cur = q.pop_front();
         n_tests = n_tests + 1;
         if (act_ctl !== cur.ctl || bus.run !== cur.run ||
             (cur.chk_alu && bus.alu_op !== cur.alu)) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got ctl=%h run=%b alu=%b, want ctl=%h run=%b alu=%b%s",
                     cur.name, act_ctl, bus.run, bus.alu_op, cur.ctl, cur.run, cur.alu,
                     cur.chk_alu ? "" : " (alu unchecked)");
         end
      end
   end

   function automatic vec_t mk(string nm, logic [31:0] ir, logic con, int n,
                               logic [26:0] e0, logic [26:0] e1, logic [26:0] e2,
                               logic [26:0] e3, logic [26:0] e4, logic [4:0] alu);
      vec_t v;
      v.name  = nm;
      v.ir    = ir;
      v.con   = con;
      v.n     = n;
      v.ex[0] = e0;
      v.ex[1] = e1;
      v.ex[2] = e2;
      v.ex[3] = e3;
      v.ex[4] = e4;
      v.alu   = alu;
      return v;
   endfunction

   task automatic push(logic [26:0] c, logic r, logic ca, logic [4:0] a, string nm);
      exp_t e;
      e.ctl     = c;
      e.run     = r;
      e.chk_alu = ca;
      e.alu     = a;
      e.name    = nm;
      q.push_back(e);
   endtask

   task automatic push_fetch(string nm);
      push(F0, 1'b1, 1'b0, 5'd0, {nm, "_t0"});
      push(F1, 1'b1, 1'b0, 5'd0, {nm, "_t1"});
      push(F2, 1'b1, 1'b0, 5'd0, {nm, "_t2"});
   endtask

   // Wait until every queued expectation has been checked; returns 1 ns after a rising edge.
   task automatic drain();
      int b;
      b = 0;
      while (q.size() != 0 && b < 64) begin
         @(posedge clk);
         b++;
      end
      #1;
      if (q.size() != 0) begin
         n_tests = n_tests + 1;
         n_fail  = n_fail + 1;
         $display("FAIL drain_timeout: %0d entries left, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic run_vec(vec_t v);
      bus.IR  = v.ir;
      bus.CON = v.con;
      push_fetch(v.name);
      for (int i = 0; i < v.n; i++) begin
         push(v.ex[i], 1'b1, v.ex[i][10], v.alu, $sformatf("%s_t%0d", v.name, i + 3));
      end
      drain();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clr     = 1'b1;
      bus.IR  = 32'h0;
      bus.CON = 1'b0;
`ifdef MEM_WAIT_EN
      bus.mem_ready = 1'b1;
`endif

      vecs[0]  = mk("add",   32'h18A98000, 1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h03);
      vecs[1]  = mk("sub",   32'h20000000, 1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h04);
      vecs[2]  = mk("rol",   32'h58000000, 1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h0B);
      vecs[3]  = mk("addi",  32'h60000000, 1'b0, 3, GRB|ROUT|YIN, COUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h0C);
      vecs[4]  = mk("ori",   32'h70000000, 1'b0, 3, GRB|ROUT|YIN, COUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h0E);
      vecs[5]  = mk("ld",    32'h00800055, 1'b0, 5, GRB|ROUT|BAOUT|YIN, COUT|ZIN, ZLOW|MARIN,
                   READ|MDRIN, MDROUT|GRA|RIN, 5'h03);
      vecs[6]  = mk("ldi",   32'h08000010, 1'b0, 3, GRB|ROUT|BAOUT|YIN, COUT|ZIN, ZLOW|GRA|RIN,
                   NONE, NONE, 5'h03);
      vecs[7]  = mk("st",    32'h10800055, 1'b0, 5, GRB|ROUT|BAOUT|YIN, COUT|ZIN, ZLOW|MARIN,
                   GRA|ROUT|MDRIN, WRITE, 5'h03);
      vecs[8]  = mk("mul",   32'h78000000, 1'b0, 4, GRA|ROUT|YIN, GRB|ROUT|ZIN, ZLOW|LOIN,
                   ZHIGH|HIIN, NONE, 5'h0F);
      vecs[9]  = mk("div",   32'h80000000, 1'b0, 4, GRA|ROUT|YIN, GRB|ROUT|ZIN, ZLOW|LOIN,
                   ZHIGH|HIIN, NONE, 5'h10);
      vecs[10] = mk("neg",   32'h88000000, 1'b0, 2, GRB|ROUT|ZIN, ZLOW|GRA|RIN, NONE,
                   NONE, NONE, 5'h11);
      vecs[11] = mk("not",   32'h90000000, 1'b0, 2, GRB|ROUT|ZIN, ZLOW|GRA|RIN, NONE,
                   NONE, NONE, 5'h12);
      vecs[12] = mk("br_c0", 32'h98000000, 1'b0, 4, GRA|ROUT|CONNIN, PCOUT|YIN, COUT|ZIN,
                   ZLOW, NONE, 5'h03);
      vecs[13] = mk("br_c1", 32'h98000000, 1'b1, 4, GRA|ROUT|CONNIN, PCOUT|YIN, COUT|ZIN,
                   ZLOW|PCIN, NONE, 5'h03);
      vecs[14] = mk("jr",    32'hA0000000, 1'b1, 1, GRA|ROUT|PCIN, NONE, NONE, NONE, NONE, 5'h0);
      vecs[15] = mk("jal",   32'hA8000000, 1'b0, 2, PCOUT|GRB|RIN, GRA|ROUT|PCIN, NONE,
                   NONE, NONE, 5'h0);
      vecs[16] = mk("in",    32'hB0000000, 1'b0, 1, INPORT|GRA|RIN, NONE, NONE, NONE, NONE, 5'h0);
      vecs[17] = mk("out",   32'hB8000000, 1'b0, 1, GRA|ROUT|OUTPORT, NONE, NONE, NONE, NONE,
                   5'h0);
      vecs[18] = mk("mfhi",  32'hC0000000, 1'b0, 1, HIOUT|GRA|RIN, NONE, NONE, NONE, NONE, 5'h0);
      vecs[19] = mk("mflo",  32'hC8000000, 1'b0, 1, LOOUT|GRA|RIN, NONE, NONE, NONE, NONE, 5'h0);
      vecs[20] = mk("nop",   32'hD0000000, 1'b0, 1, NONE, NONE, NONE, NONE, NONE, 5'h0);
      vecs[21] = mk("unused",32'hF8000000, 1'b0, 1, NONE, NONE, NONE, NONE, NONE, 5'h0);

      // Reset: everything off, run high, alu_op zero.
      push(NONE, 1'b1, 1'b1, 5'd0, "reset0");
      push(NONE, 1'b1, 1'b1, 5'd0, "reset1");
      drain();
      clr = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // halt: one idle T3, then run low with all controls off until clr.
      bus.IR = 32'hD8000000;
      push_fetch("halt");
      push(NONE, 1'b1, 1'b0, 5'd0, "halt_t3");
      for (int i = 0; i < 20; i++) push(NONE, 1'b0, 1'b1, 5'd0, $sformatf("halted%0d", i));
      drain();
      clr = 1'b1;
      push(NONE, 1'b1, 1'b1, 5'd0, "halt_clr");
      drain();
      clr = 1'b0;

      // clr during T5 of ld: the pending read/Rin steps must never appear.
      bus.IR = 32'h00800055;
      push_fetch("ld_ab");
      push(GRB|ROUT|BAOUT|YIN, 1'b1, 1'b0, 5'd0, "ld_ab_t3");
      push(COUT|ZIN, 1'b1, 1'b1, 5'h03, "ld_ab_t4");
      drain();
      clr = 1'b1;
      push(NONE, 1'b1, 1'b1, 5'd0, "ld_ab_clr");
      drain();
      clr = 1'b0;
      bus.IR = 32'hD0000000;
      push_fetch("post_ab");
      push(NONE, 1'b1, 1'b0, 5'd0, "post_ab_t3");
      drain();

`ifdef MEM_WAIT_EN
      // st with mem_ready low for three cycles in T7: write held for four cycles.
      bus.IR = 32'h10800055;
      push_fetch("st_w");
      push(GRB|ROUT|BAOUT|YIN, 1'b1, 1'b0, 5'd0, "st_w_t3");
      push(COUT|ZIN, 1'b1, 1'b1, 5'h03, "st_w_t4");
      push(ZLOW|MARIN, 1'b1, 1'b0, 5'd0, "st_w_t5");
      push(GRA|ROUT|MDRIN, 1'b1, 1'b0, 5'd0, "st_w_t6");
      drain();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(WRITE, 1'b1, 1'b0, 5'd0, $sformatf("st_w_hold%0d", i));
      drain();
      bus.mem_ready = 1'b1;
      push(WRITE, 1'b1, 1'b0, 5'd0, "st_w_t7");
      drain();
`endif

      run_vec(vecs[20]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
